vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/pong_pkg.sv | 31 +++
 rtl/vga_px_pipe.sv | 46 ++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong video path.
// Holds the standard 640x480@60 timing numbers, the default colour depth,
// the rgb channel struct and a small window-compare helper used to decode
// the sync intervals from the raster counters.
package pong_pkg;

    localparam int PONG_H_ACTIVE   = 32'd640;
    localparam int PONG_H_FP       = 32'd16;
    localparam int PONG_H_SYNC     = 32'd96;
    localparam int PONG_H_BP       = 32'd48;
    localparam int PONG_V_ACTIVE   = 32'd480;
    localparam int PONG_V_FP       = 32'd10;
    localparam int PONG_V_SYNC     = 32'd2;
    localparam int PONG_V_BP       = 32'd33;
    localparam int PONG_COLOR_BITS = 32'd4;

    typedef struct packed {
        logic [PONG_COLOR_BITS-1:0] red;
        logic [PONG_COLOR_BITS-1:0] green;
        logic [PONG_COLOR_BITS-1:0] blue;
    } rgb_t;

    // True when val lies in [lo, lo+len-1]; done at 32 bits so that a window
    // ending exactly at the line/frame total cannot overflow the counter width.
    function automatic logic in_window(input logic [31:0] val,
                                       input logic [31:0] lo,
                                       input logic [31:0] len);
        return (val >= lo) && (val < (lo + len));
    endfunction

endpackage

// File: rtl/vga_px_pipe.sv
// Strobe-enabled delay line for the pad-side pixel data.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears all stages)
//   clr        : synchronous clear of all stages (generator idle)
//   stb        : pixel strobe; stages shift only when high, hold otherwise
//   din        : data captured on the strobe
//   dout       : last stage, i.e. din delayed by DEPTH strobes
module vga_px_pipe
    import pong_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             stb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
        $error("vga_px_pipe: DEPTH must be in 1..4");
    end

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register advancing one stage per pixel strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_r <= '{default: '0};
        end else if (clr) begin
            stage_r <= '{default: '0};
        end else if (stb) begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end else begin
            stage_r <= stage_r;
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with aligned pad outputs.
// A clock divider produces the pixel strobe; horizontal/vertical counters
// walk the raster; sync levels and blanked colour are pushed through a
// PIPE-deep strobe-enabled delay line so colour and syncs reach the pads
// together.
// Ports:
//   clk, reset, enable          : clock, async active-high reset, run enable
//   pix_en                      : one-clk pixel strobe
//   hcount, vcount              : current column / line
//   active                      : current position is inside the visible area
//   line_start, frame_start     : one-clk pulses at column 0 / pixel (0,0)
//   red_in, green_in, blue_in   : colour for the current hcount/vcount
//   red, green, blue            : registered pad colour
//   hsync, vsync                : registered pad syncs
//   frame_cnt                   : completed-frame counter (wraps at 2^16)
module vga_timing_gen
    import pong_pkg::*;
#(
    parameter int H_ACTIVE   = PONG_H_ACTIVE,
    parameter int H_FP       = PONG_H_FP,
    parameter int H_SYNC     = PONG_H_SYNC,
    parameter int H_BP       = PONG_H_BP,
    parameter int V_ACTIVE   = PONG_V_ACTIVE,
    parameter int V_FP       = PONG_V_FP,
    parameter int V_SYNC     = PONG_V_SYNC,
    parameter int V_BP       = PONG_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 32'd1,
    parameter int COLOR_BITS = PONG_COLOR_BITS,
    parameter int PIPE       = 32'd2,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  pix_en,
    output logic [HW-1:0]         hcount,
    output logic [VW-1:0]         vcount,
    output logic                  active,
    output logic                  line_start,
    output logic                  frame_start,
    input  logic [COLOR_BITS-1:0] red_in,
    input  logic [COLOR_BITS-1:0] green_in,
    input  logic [COLOR_BITS-1:0] blue_in,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic [15:0]           frame_cnt
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((PIPE < 1) || (PIPE > 4)) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE must be in 1..4");
    end

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PIPE_W = 3 * COLOR_BITS + 2;

    logic [DIV_W-1:0]      div_r;
    logic [HW-1:0]         hcount_r;
    logic [VW-1:0]         vcount_r;
    logic [15:0]           frame_cnt_r;

    logic                  div_last_s;
    logic                  pix_en_s;
    logic                  h_last_s;
    logic                  v_last_s;
    logic                  in_area_s;
    logic                  hs_raw_s;
    logic                  vs_raw_s;
    logic [COLOR_BITS-1:0] red_blank_s;
    logic [COLOR_BITS-1:0] green_blank_s;
    logic [COLOR_BITS-1:0] blue_blank_s;
    logic [PIPE_W-1:0]     pipe_din_s;
    logic [PIPE_W-1:0]     pipe_dout_s;

    // With CLK_DIV=1 the last-count value is 0, so the divider sits at 0 and
    // the strobe stays high. The strobe is gated by enable combinationally so
    // that the very first enabled cycle already carries a strobe at (0,0).
    assign div_last_s = (div_r == DIV_W'(CLK_DIV - 1));
    assign pix_en_s   = enable && !reset && (div_r == '0);
    assign h_last_s   = (hcount_r == HW'(H_TOTAL - 1));
    assign v_last_s   = (vcount_r == VW'(V_TOTAL - 1));
    assign in_area_s  = (hcount_r < HW'(H_ACTIVE)) && (vcount_r < VW'(V_ACTIVE));

    assign hs_raw_s = in_window(32'(hcount_r), 32'(H_ACTIVE + H_FP), 32'(H_SYNC));
    assign vs_raw_s = in_window(32'(vcount_r), 32'(V_ACTIVE + V_FP), 32'(V_SYNC));

    assign red_blank_s   = in_area_s ? red_in   : '0;
    assign green_blank_s = in_area_s ? green_in : '0;
    assign blue_blank_s  = in_area_s ? blue_in  : '0;

    // Clock divider producing one strobe every CLK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= '0;
        end else if (!enable) begin
            div_r <= '0;
        end else if (div_last_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Raster position counters, advanced on each pixel strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_r <= '0;
            vcount_r <= '0;
        end else if (!enable) begin
            hcount_r <= '0;
            vcount_r <= '0;
        end else if (pix_en_s) begin
            if (h_last_s) begin
                hcount_r <= '0;
                if (v_last_s) begin
                    vcount_r <= '0;
                end else begin
                    vcount_r <= vcount_r + VW'(1);
                end
            end else begin
                hcount_r <= hcount_r + HW'(1);
                vcount_r <= vcount_r;
            end
        end else begin
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

    // Completed-frame counter; survives enable dropping, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (pix_en_s && h_last_s && v_last_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Syncs travel as "asserted" flags so a cleared stage means deasserted.
    assign pipe_din_s = {red_blank_s, green_blank_s, blue_blank_s, hs_raw_s, vs_raw_s};

    vga_px_pipe #(
        .WIDTH (PIPE_W),
        .DEPTH (PIPE)
    ) u_px_pipe (
        .clk   (clk),
        .reset (reset),
        .clr   (!enable),
        .stb   (pix_en_s),
        .din   (pipe_din_s),
        .dout  (pipe_dout_s)
    );

    assign pix_en      = pix_en_s;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign active      = in_area_s && enable && !reset;
    assign line_start  = pix_en_s && (hcount_r == '0);
    assign frame_start = pix_en_s && (hcount_r == '0) && (vcount_r == '0);
    assign frame_cnt   = frame_cnt_r;

    assign red   = pipe_dout_s[PIPE_W-1 -: COLOR_BITS];
    assign green = pipe_dout_s[2*COLOR_BITS+1 -: COLOR_BITS];
    assign blue  = pipe_dout_s[COLOR_BITS+1 -: COLOR_BITS];
    assign hsync = pipe_dout_s[1] ? HSYNC_POL : ~HSYNC_POL;
    assign vsync = pipe_dout_s[0] ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 16x8 raster
// (H 8/2/3/3, V 4/1/2/1, CLK_DIV=2, PIPE=2, active-low syncs).
// Expected values come from the raster arithmetic: counting cycles k from
// the first enabled cycle, the current pixel is P=(k+1)/2 and the pad
// outputs show pixel P-2.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pix_en;
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic [3:0]  red_in;
    logic [3:0]  green_in;
    logic [3:0]  blue_in;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    vga_timing_gen #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (3),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .HSYNC_POL  (1'b0),
        .VSYNC_POL  (1'b0),
        .CLK_DIV    (2),
        .COLOR_BITS (4),
        .PIPE       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .line_start  (line_start),
        .frame_start (frame_start),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_pix_en"},      32'(pix_en),      32'd0);
        chk({pfx, "_line_start"},  32'(line_start),  32'd0);
        chk({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({pfx, "_active"},      32'(active),      32'd0);
        chk({pfx, "_red"},         32'(red),         32'd0);
        chk({pfx, "_green"},       32'(green),       32'd0);
        chk({pfx, "_blue"},        32'(blue),        32'd0);
        chk({pfx, "_hsync"},       32'(hsync),       32'd1);
        chk({pfx, "_vsync"},       32'(vsync),       32'd1);
        chk({pfx, "_hcount"},      32'(hcount),      32'd0);
        chk({pfx, "_vcount"},      32'(vcount),      32'd0);
        chk({pfx, "_frame_cnt"},   32'(frame_cnt),   32'd0);
    endtask

    // Expected outputs at cycle k after enable, red_in=F green_in=3 blue_in=C.
    task automatic check_all(input int k, input logic [15:0] fc0);
        int p, h, v, q, hq, vq;
        logic pe, act, hs, vs;
        logic [3:0] er, eg, eb;
        logic [15:0] efc;
        p   = (k + 1) / 2;
        h   = p % 16;
        v   = (p / 16) % 8;
        pe  = ((k % 2) == 0);
        efc = fc0 + 16'(p / 128);
        q   = p - 2;
        if (q < 0) begin
            hs = 1'b1; vs = 1'b1; er = 4'h0; eg = 4'h0; eb = 4'h0;
        end else begin
            hq  = q % 16;
            vq  = (q / 16) % 8;
            act = (hq < 8) && (vq < 4);
            hs  = !((hq >= 10) && (hq <= 12));
            vs  = !((vq >= 5) && (vq <= 6));
            er  = act ? 4'hF : 4'h0;
            eg  = act ? 4'h3 : 4'h0;
            eb  = act ? 4'hC : 4'h0;
        end
        chk($sformatf("pix_en@%0d", k),      32'(pix_en),      32'(pe));
        chk($sformatf("hcount@%0d", k),      32'(hcount),      32'(h));
        chk($sformatf("vcount@%0d", k),      32'(vcount),      32'(v));
        chk($sformatf("line_start@%0d", k),  32'(line_start),  32'(pe && (h == 0)));
        chk($sformatf("frame_start@%0d", k), 32'(frame_start), 32'(pe && (h == 0) && (v == 0)));
        chk($sformatf("active@%0d", k),      32'(active),      32'((h < 8) && (v < 4)));
        chk($sformatf("frame_cnt@%0d", k),   32'(frame_cnt),   32'(efc));
        chk($sformatf("hsync@%0d", k),       32'(hsync),       32'(hs));
        chk($sformatf("vsync@%0d", k),       32'(vsync),       32'(vs));
        chk($sformatf("red@%0d", k),         32'(red),         32'(er));
        chk($sformatf("green@%0d", k),       32'(green),       32'(eg));
        chk($sformatf("blue@%0d", k),        32'(blue),        32'(eb));
    endtask

    // Checks cycles k_from..k_to; starts at a falling edge, ends at the next one after k_to.
    task automatic run_span(input int k_from, input int k_to, input logic [15:0] fc0);
        for (int k = k_from; k <= k_to; k++) begin
            #1;
            check_all(k, fc0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        red_in   = 4'hF;
        green_in = 4'h3;
        blue_in  = 4'hC;

        // Reset state.
        @(negedge clk);
        #1;
        check_reset_vals("rst");

        // Free run: strobe cadence, counters, syncs, colour alignment, first frame.
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        run_span(0, 329, 16'd0);

        // Drop enable at hcount=5, vcount=2 for 10 clocks.
        chk("drop_pos_h", 32'(hcount), 32'd5);
        chk("drop_pos_v", 32'(vcount), 32'd2);
        enable = 1'b0;
        #1;
        chk("idle_pix_en_now", 32'(pix_en), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("idle_pix_en",    32'(pix_en),    32'd0);
        chk("idle_hsync",     32'(hsync),     32'd1);
        chk("idle_vsync",     32'(vsync),     32'd1);
        chk("idle_red",       32'(red),       32'd0);
        chk("idle_green",     32'(green),     32'd0);
        chk("idle_blue",      32'(blue),      32'd0);
        chk("idle_hcount",    32'(hcount),    32'd0);
        chk("idle_vcount",    32'(vcount),    32'd0);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'd1);

        // Restart from (0,0) with frame_cnt kept.
        @(negedge clk);
        enable = 1'b1;
        run_span(0, 17, 16'd1);

        // Asynchronous reset mid-line at hcount=9, checked before any clock edge.
        chk("pre_rst_hcount", 32'(hcount), 32'd9);
        chk("pre_rst_red",    32'(red),    32'hF);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_span(0, 40, 16'd0);

        // Preload the frame counter near the top and run two frames through the wrap.
        force dut.frame_cnt_r = 16'hFFFE;
        #1;
        release dut.frame_cnt_r;
        run_span(41, 520, 16'hFFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
